sysid_regfile: RTL and testbench

SYSID_REGFILE -- requirements
Module: sysid_regfile

---
 rtl/sysid_pkg.sv | 27 ++
 rtl/sysid_uptime_counter.sv | 39 +++
 rtl/sysid_regfile.sv | 100 ++++++++++
 tb/tb_sysid_regfile.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID register file: the address map, CTRL bit
// positions and the default capability version.
package sysid_pkg;
  localparam logic [3:0] ADDR_ID           = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP    = 4'd1;
  localparam logic [3:0] ADDR_UPTIME_LO    = 4'd2;
  localparam logic [3:0] ADDR_UPTIME_HI    = 4'd3;
  localparam logic [3:0] ADDR_CAP          = 4'd4;
  localparam logic [3:0] ADDR_CTRL         = 4'd5;
  localparam logic [3:0] ADDR_SCRATCH_BASE = 4'd8;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam logic [7:0] CAP_VERSION_DEFAULT = 8'h02;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit uptime counter with enable and clear, plus a snapshot of
// the upper word taken whenever the lower word is read.
module sysid_uptime_counter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  input  logic        snap,
  output logic [63:0] cnt,
  output logic [31:0] hi_snap
);
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 64'd1;
  end

  // The snapshot samples the current (pre-clear) value so LO/HI stay coherent.
  always_comb begin
    snap_d = snap_q;
    if (snap) snap_d = cnt_q[63:32];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign cnt     = cnt_q;
  assign hi_snap = snap_q;
endmodule

// File: rtl/sysid_regfile.sv
// Avalon-MM system-ID register file: constant ID/timestamp/capability words,
// uptime counter with control, and byte-writable scratch registers.
module sysid_regfile
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_ID        = 32'h0000_0000,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'h0000_0000,
  parameter int          NUM_SCRATCH     = 2,
  parameter logic [7:0]  CAP_VERSION     = CAP_VERSION_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);
  localparam logic [3:0]  NS4      = 4'(NUM_SCRATCH);
  localparam logic [31:0] CAP_WORD = {16'h0, 4'h0, NS4, CAP_VERSION};

  logic                             en_q, en_d;
  logic [NUM_SCRATCH-1:0][31:0]     scratch_q, scratch_d;
  logic [31:0]                      rdata_q, rdata_d;
  logic                             rdv_q, rdv_d;
  logic                             wr_ok, clr, snap;
  logic [63:0]                      cnt;
  logic [31:0]                      hi_snap;

  // A simultaneous read wins; the write is dropped.
  assign wr_ok = write && !read;
  assign snap  = read && (address == ADDR_UPTIME_LO);

  always_comb begin
    en_d = en_q;
    clr  = 1'b0;
    if (wr_ok && address == ADDR_CTRL && byteenable[0]) begin
      en_d = writedata[CTRL_EN_BIT];
      clr  = writedata[CTRL_CLR_BIT];
    end
  end

  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (wr_ok && address == ADDR_SCRATCH_BASE + i[3:0])
        scratch_d[i] = be_merge(scratch_q[i], writedata, byteenable);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    rdv_d   = read;
    if (read) begin
      rdata_d = '0;
      case (address)
        ADDR_ID:        rdata_d = SYSID_ID;
        ADDR_TIMESTAMP: rdata_d = SYSID_TIMESTAMP;
        ADDR_UPTIME_LO: rdata_d = cnt[31:0];
        ADDR_UPTIME_HI: rdata_d = hi_snap;
        ADDR_CAP:       rdata_d = CAP_WORD;
        ADDR_CTRL:      rdata_d = {31'h0, en_q};
        default: begin
          for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == ADDR_SCRATCH_BASE + i[3:0]) rdata_d = scratch_q[i];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= 1'b1;
      scratch_q <= '0;
      rdata_q   <= '0;
      rdv_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rdv_q     <= rdv_d;
    end
  end

  sysid_uptime_counter u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (en_q),
    .clr     (clr),
    .snap    (snap),
    .cnt     (cnt),
    .hi_snap (hi_snap)
  );

  assign readdata      = rdata_q;
  assign readdatavalid = rdv_q;
endmodule

// File: tb/tb_sysid_regfile.sv
// Directed bench for sysid_regfile: inputs change on the falling edge, outputs
// are checked on the following falling edge.
module tb_sysid_regfile;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sysid_regfile #(
    .SYSID_ID        (32'h5AA7_F2BD),
    .SYSID_TIMESTAMP (32'h2024_0611),
    .NUM_SCRATCH     (2),
    .CAP_VERSION     (8'h02)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clock);
    address = a; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    chk($sformatf("rdv_addr%0d", a), {31'h0, readdatavalid}, 32'h1);
    d = readdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
    @(negedge clock);
    address = a; writedata = wd; byteenable = be; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    repeat (3) @(negedge clock);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_rdv", {31'h0, readdatavalid}, 32'h0);
    reset_n = 1'b1;

    rd(ADDR_ID_T, d);
    chk("id", d, 32'h5AA7_F2BD);
    @(negedge clock);
    chk("rdv_pulse_one_cycle", {31'h0, readdatavalid}, 32'h0);
    chk("readdata_hold", readdata, 32'h5AA7_F2BD);

    rd(4'd1, d);  chk("timestamp", d, 32'h2024_0611);
    rd(4'd4, d);  chk("cap", d, 32'h0000_0202);
    rd(4'd5, d);  chk("ctrl_reset", d, 32'h1);
    rd(4'd3, d);  chk("hi_snap_reset", d, 32'h0);

    // back-to-back reads on consecutive cycles
    @(negedge clock); address = 4'd1; read = 1'b1;
    @(negedge clock); address = 4'd0;
    chk("b2b_first", readdata, 32'h2024_0611);
    @(negedge clock); read = 1'b0;
    chk("b2b_second", readdata, 32'h5AA7_F2BD);
    chk("b2b_rdv", {31'h0, readdatavalid}, 32'h1);

    // counter runs: reads are exactly two edges apart
    rd(4'd2, d); rd(4'd2, d2);
    chk("uptime_delta", d2 - d, 32'd2);

    // byte-lane writes
    rd(4'd8, d);  chk("scratch0_reset", d, 32'h0);
    wr(4'd8, 32'hDEAD_BEEF, 4'b0101);
    rd(4'd8, d);  chk("scratch0_be0101", d, 32'h00AD_00EF);
    wr(4'd8, 32'h1234_5678, 4'b0000);
    rd(4'd8, d);  chk("scratch0_be0000", d, 32'h00AD_00EF);

    // write followed immediately by read of the same address
    @(negedge clock); address = 4'd9; writedata = 32'hCAFE_F00D; byteenable = 4'hF; write = 1'b1;
    @(negedge clock); write = 1'b0; read = 1'b1;
    @(negedge clock); read = 1'b0;
    chk("scratch1_wr_then_rd", readdata, 32'hCAFE_F00D);

    // unmapped accesses
    rd(4'd15, d); chk("unmapped15", d, 32'h0);
    rd(4'd6, d);  chk("unmapped6", d, 32'h0);
    wr(4'd15, 32'hFFFF_FFFF, 4'hF);
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd(4'd0, d);  chk("id_write_ignored", d, 32'h5AA7_F2BD);
    rd(4'd8, d);  chk("scratch0_after_unmapped_wr", d, 32'h00AD_00EF);
    rd(4'd9, d);  chk("scratch1_after_unmapped_wr", d, 32'hCAFE_F00D);

    // simultaneous read and write: read serviced, write lost
    @(negedge clock); address = 4'd8; writedata = 32'h1111_1111; byteenable = 4'hF;
    read = 1'b1; write = 1'b1;
    @(negedge clock); read = 1'b0; write = 1'b0;
    chk("rw_same_cycle_old", readdata, 32'h00AD_00EF);
    rd(4'd8, d);  chk("rw_same_cycle_write_lost", d, 32'h00AD_00EF);

    // clear with EN=0, then freeze
    @(negedge clock); address = 4'd5; writedata = 32'h2; byteenable = 4'hF; write = 1'b1;
    @(negedge clock); write = 1'b0; address = 4'd2; read = 1'b1;
    @(negedge clock); read = 1'b0;
    chk("uptime_after_clr", readdata, 32'h0);
    rd(4'd5, d);  chk("ctrl_en0_clr_reads0", d, 32'h0);
    wr(4'd5, 32'h0, 4'hF);
    rd(4'd2, d);
    repeat (10) @(negedge clock);
    rd(4'd2, d2); chk("uptime_frozen", d2, d);

    // preload near a 32-bit carry, then split read across the carry
    @(negedge clock); force dut.u_uptime.cnt_q = 64'h0000_0001_FFFF_FFFF;
    @(negedge clock); release dut.u_uptime.cnt_q;
    @(negedge clock);
    rd(4'd2, d);  chk("uptime_lo_pre_carry", d, 32'hFFFF_FFFF);
    wr(4'd5, 32'h1, 4'hF);
    repeat (4) @(negedge clock);
    rd(4'd3, d);  chk("hi_snap_holds", d, 32'h0000_0001);
    rd(4'd2, d);
    rd(4'd3, d);  chk("hi_snap_after_carry", d, 32'h0000_0002);
    rd(4'd5, d);  chk("ctrl_en1", d, 32'h1);

    // reset while a read is in flight
    wr(4'd5, 32'h0, 4'hF);
    @(negedge clock); address = 4'd0; read = 1'b1;
    #2 reset_n = 1'b0; read = 1'b0;
    @(negedge clock);
    chk("rst_mid_rdv", {31'h0, readdatavalid}, 32'h0);
    chk("rst_mid_readdata", readdata, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_no_rdv", {31'h0, readdatavalid}, 32'h0);
    rd(4'd5, d);  chk("post_rst_ctrl", d, 32'h1);
    rd(4'd8, d);  chk("post_rst_scratch0", d, 32'h0);
    rd(4'd3, d);  chk("post_rst_hi_snap", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  localparam logic [3:0] ADDR_ID_T = 4'd0;
  localparam logic [3:0] ADDR_UNUSED_T = 4'd0;
endmodule
